// File: rtl/mult_div_unit.sv
// mult_div_unit: 32-step signed shift-add multiplier and restoring
// divider producing the HIGH/LOW results for the multicycle core.

module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] MultHigh,
  output logic [WIDTH-1:0] MultLow,
  output logic [WIDTH-1:0] DivHigh,
  output logic [WIDTH-1:0] DivLow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    ERR
  } state_t;

  state_t state;
  state_t stateNext;

  logic capture;
  logic lastStep;
  logic bZero;

  logic [CW-1:0] count;
  logic          opDiv;
  logic          negProd;
  logic          negRem;

  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] accStep;
  logic [WIDTH:0]     addSum;

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] remStep;
  logic [WIDTH-1:0] quoStep;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  logic [WIDTH-1:0] multHighQ;
  logic [WIDTH-1:0] multLowQ;
  logic [WIDTH-1:0] divHighQ;
  logic [WIDTH-1:0] divLowQ;

  assign absA     = A[WIDTH-1] ? -A : A;
  assign absB     = B[WIDTH-1] ? -B : B;
  assign bZero    = (B == '0);
  assign lastStep = (state == RUN) && (count == LastCount);

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next state; DONE also serves as the first sampling slot so
  // back-to-back operations lose no cycle
  always_comb begin
    stateNext = state;
    capture   = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        stateNext = IDLE;
        if (Start) begin
          if (Op && bZero) begin
            stateNext = ERR;
          end else begin
            stateNext = RUN;
            capture   = 1'b1;
          end
        end
      end
      RUN: begin
        if (count == LastCount) begin
          stateNext = DONE;
        end
      end
      ERR: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // One multiply step: low half of acc holds the multiplier
  // and shifts out as product bits shift in from the top
  always_comb begin
    addSum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
            + {1'b0, (acc[0] ? magA : {WIDTH{1'b0}})};
    accStep = {addSum, acc[WIDTH-1:1]};
  end

  // One restoring divide step: quo holds remaining dividend
  // bits above and finished quotient bits below
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, magB};
    if (trial[WIDTH]) begin
      remStep = shifted[WIDTH-1:0];
      quoStep = {quo[WIDTH-2:0], 1'b0};
    end else begin
      remStep = trial[WIDTH-1:0];
      quoStep = {quo[WIDTH-2:0], 1'b1};
    end
  end

  // Operand capture, iteration and signed result load
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count     <= '0;
      opDiv     <= 1'b0;
      negProd   <= 1'b0;
      negRem    <= 1'b0;
      magA      <= '0;
      magB      <= '0;
      acc       <= '0;
      rem       <= '0;
      quo       <= '0;
      multHighQ <= '0;
      multLowQ  <= '0;
      divHighQ  <= '0;
      divLowQ   <= '0;
    end else if (capture) begin
      count   <= '0;
      opDiv   <= Op;
      negProd <= A[WIDTH-1] ^ B[WIDTH-1];
      negRem  <= A[WIDTH-1];
      magA    <= absA;
      magB    <= absB;
      acc     <= {{WIDTH{1'b0}}, absB};
      rem     <= '0;
      quo     <= absA;
    end else if (state == RUN) begin
      count <= count + 1'b1;
      if (opDiv) begin
        rem <= remStep;
        quo <= quoStep;
      end else begin
        acc <= accStep;
      end
      if (lastStep) begin
        if (opDiv) begin
          divLowQ  <= negProd ? -quoStep : quoStep;
          divHighQ <= negRem ? -remStep : remStep;
        end else begin
          {multHighQ, multLowQ} <= negProd ? -accStep : accStep;
        end
      end
    end
  end

  assign Busy     = (state == RUN) || (state == DONE);
  assign Done     = (state == DONE);
  assign DivZero  = (state == ERR);
  assign MultHigh = multHighQ;
  assign MultLow  = multLowQ;
  assign DivHigh  = divHighQ;
  assign DivLow   = divLowQ;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: random and directed checks of mult_div_unit
// against a plain 64-bit arithmetic reference.

module tb_mult_div_unit;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic        Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic        DivZero;
  logic [31:0] MultHigh;
  logic [31:0] MultLow;
  logic [31:0] DivHigh;
  logic [31:0] DivLow;

  int nChecks = 0;
  int nFail   = 0;

  logic [31:0] expMH;
  logic [31:0] expML;
  logic [31:0] expDH;
  logic [31:0] expDL;

  mult_div_unit #(.WIDTH(32)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Start(Start),
    .Op(Op),
    .A(A),
    .B(B),
    .Busy(Busy),
    .Done(Done),
    .DivZero(DivZero),
    .MultHigh(MultHigh),
    .MultLow(MultLow),
    .DivHigh(DivHigh),
    .DivLow(DivLow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference: signed 64-bit arithmetic, truncating division
  task automatic model(input logic op, input logic [31:0] a,
                       input logic [31:0] b);
    longint la;
    longint lb;
    longint p;
    longint q;
    longint r;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    if (!op) begin
      p = la * lb;
      expMH = p[63:32];
      expML = p[31:0];
    end else begin
      q = la / lb;
      r = la % lb;
      expDL = q[31:0];
      expDH = r[31:0];
    end
  endtask

  // Issue one op, return cycles to Done (0 = timeout)
  task automatic runOp(input logic op, input logic [31:0] a,
                       input logic [31:0] b, output int lat);
    @(negedge Clk);
    Start = 1'b1;
    Op = op;
    A = a;
    B = b;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    A = $urandom;
    B = $urandom;
    Op = 1'($urandom);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge Clk);
      if (Done) begin
        lat = i;
        break;
      end
    end
    model(op, a, b);
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    Start = 1'b0;
    Op = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(negedge Clk);
    expMH = '0;
    expML = '0;
    expDH = '0;
    expDL = '0;
    nChecks++;
    if ({Busy, Done, DivZero} !== 3'b000) begin
      nFail++;
      $display("FAIL reset_flags got %b want 000", {Busy, Done, DivZero});
    end
    nChecks++;
    if ({MultHigh, MultLow} !== 64'h0) begin
      nFail++;
      $display("FAIL reset_mult got %h%h want 0", MultHigh, MultLow);
    end
    nChecks++;
    if ({DivHigh, DivLow} !== 64'h0) begin
      nFail++;
      $display("FAIL reset_div got %h%h want 0", DivHigh, DivLow);
    end
  endtask

  task automatic test_mult;
    int lat;
    runOp(1'b0, 32'd7, 32'hFFFFFFFD, lat);
    nChecks++;
    if (lat !== 33) begin
      nFail++;
      $display("FAIL mult_latency got %0d want 33", lat);
    end
    nChecks++;
    if ({MultHigh, MultLow} !== 64'hFFFFFFFF_FFFFFFEB) begin
      nFail++;
      $display("FAIL mult_7x-3 got %h_%h want FFFFFFFF_FFFFFFEB",
               MultHigh, MultLow);
    end
    nChecks++;
    if ({DivHigh, DivLow} !== 64'h0) begin
      nFail++;
      $display("FAIL mult_div_untouched got %h_%h want 0",
               DivHigh, DivLow);
    end
    runOp(1'b0, 32'h80000000, 32'h80000000, lat);
    nChecks++;
    if ({MultHigh, MultLow} !== 64'h40000000_00000000) begin
      nFail++;
      $display("FAIL mult_minmin got %h_%h want 40000000_00000000",
               MultHigh, MultLow);
    end
    runOp(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    nChecks++;
    if ({MultHigh, MultLow} !== 64'h00000000_00000001) begin
      nFail++;
      $display("FAIL mult_m1m1 got %h_%h want 00000000_00000001",
               MultHigh, MultLow);
    end
  endtask

  task automatic test_div;
    int lat;
    runOp(1'b1, 32'hFFFFFFF9, 32'd2, lat);
    nChecks++;
    if (lat !== 33) begin
      nFail++;
      $display("FAIL div_latency got %0d want 33", lat);
    end
    nChecks++;
    if ({DivHigh, DivLow} !== 64'hFFFFFFFF_FFFFFFFD) begin
      nFail++;
      $display("FAIL div_-7/2 got %h_%h want FFFFFFFF_FFFFFFFD",
               DivHigh, DivLow);
    end
    nChecks++;
    if ({MultHigh, MultLow} !== 64'h00000000_00000001) begin
      nFail++;
      $display("FAIL div_mult_untouched got %h_%h want 0_1",
               MultHigh, MultLow);
    end
    runOp(1'b1, 32'h80000000, 32'hFFFFFFFF, lat);
    nChecks++;
    if ({DivHigh, DivLow} !== 64'h00000000_80000000) begin
      nFail++;
      $display("FAIL div_overflow got %h_%h want 00000000_80000000",
               DivHigh, DivLow);
    end
  endtask

  task automatic test_div_zero;
    logic sawDone;
    logic sawBusy;
    logic sawDz;
    @(negedge Clk);
    Start = 1'b1;
    Op = 1'b1;
    A = 32'd5;
    B = 32'd0;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    @(negedge Clk);
    nChecks++;
    if ({DivZero, Busy, Done} !== 3'b100) begin
      nFail++;
      $display("FAIL dz_pulse got dz/busy/done %b want 100",
               {DivZero, Busy, Done});
    end
    sawDone = 1'b0;
    sawBusy = 1'b0;
    sawDz = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      sawDone |= Done;
      sawBusy |= Busy;
      sawDz |= DivZero;
    end
    nChecks++;
    if ({sawDone, sawBusy, sawDz} !== 3'b000) begin
      nFail++;
      $display("FAIL dz_after got done/busy/dz %b want 000",
               {sawDone, sawBusy, sawDz});
    end
    nChecks++;
    if ({DivHigh, DivLow} !== {expDH, expDL}) begin
      nFail++;
      $display("FAIL dz_hold got %h_%h want %h_%h",
               DivHigh, DivLow, expDH, expDL);
    end
  endtask

  task automatic test_random;
    int lat;
    logic op;
    logic [31:0] a;
    logic [31:0] b;
    for (int n = 0; n < 24; n++) begin
      op = 1'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'h80000000;
        1: b = 32'($urandom_range(1, 9));
        2: b = 32'hFFFFFFFF;
        3: a = 32'($urandom_range(0, 3));
        default: ;
      endcase
      if (op && b == 32'd0) b = 32'd1;
      runOp(op, a, b, lat);
      nChecks++;
      if (lat !== 33) begin
        nFail++;
        $display("FAIL rand_latency op=%0d got %0d want 33", op, lat);
      end
      nChecks++;
      if ({MultHigh, MultLow, DivHigh, DivLow}
          !== {expMH, expML, expDH, expDL}) begin
        nFail++;
        $display("FAIL rand op=%0d a=%h b=%h got %h %h %h %h want %h %h %h %h",
                 op, a, b, MultHigh, MultLow, DivHigh, DivLow,
                 expMH, expML, expDH, expDL);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [31:0] a2;
    logic [31:0] b2;
    int lat;
    a1 = $urandom;
    b1 = $urandom;
    a2 = $urandom;
    b2 = $urandom | 32'h10;
    @(negedge Clk);
    Start = 1'b1;
    Op = 1'b0;
    A = a1;
    B = b1;
    @(posedge Clk);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge Clk);
      if (i == 1) begin
        nChecks++;
        if (Busy !== 1'b1) begin
          nFail++;
          $display("FAIL b2b_busy_rise got %b want 1", Busy);
        end
      end
      if (Done) begin
        lat = i;
        break;
      end
      A = $urandom;
      B = $urandom;
      Op = 1'($urandom);
    end
    model(1'b0, a1, b1);
    nChecks++;
    if (lat !== 33) begin
      nFail++;
      $display("FAIL b2b_lat1 got %0d want 33", lat);
    end
    nChecks++;
    if ({MultHigh, MultLow} !== {expMH, expML}) begin
      nFail++;
      $display("FAIL b2b_mult got %h_%h want %h_%h",
               MultHigh, MultLow, expMH, expML);
    end
    Op = 1'b1;
    A = a2;
    B = b2;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    A = $urandom;
    B = $urandom;
    @(negedge Clk);
    nChecks++;
    if ({Busy, Done} !== 2'b10) begin
      nFail++;
      $display("FAIL b2b_accept got busy/done %b want 10", {Busy, Done});
    end
    lat = 0;
    for (int i = 2; i <= 41; i++) begin
      @(negedge Clk);
      if (Done) begin
        lat = i;
        break;
      end
    end
    model(1'b1, a2, b2);
    nChecks++;
    if (lat !== 33) begin
      nFail++;
      $display("FAIL b2b_lat2 got %0d want 33", lat);
    end
    nChecks++;
    if ({MultHigh, MultLow, DivHigh, DivLow}
        !== {expMH, expML, expDH, expDL}) begin
      nFail++;
      $display("FAIL b2b_div got %h %h %h %h want %h %h %h %h",
               MultHigh, MultLow, DivHigh, DivLow,
               expMH, expML, expDH, expDL);
    end
  endtask

  task automatic test_reset_midrun;
    logic sawDone;
    int lat;
    @(negedge Clk);
    Start = 1'b1;
    Op = 1'b0;
    A = $urandom;
    B = $urandom;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    repeat (11) @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(negedge Clk);
    nChecks++;
    if ({Busy, Done, DivZero} !== 3'b000) begin
      nFail++;
      $display("FAIL midrst_flags got %b want 000", {Busy, Done, DivZero});
    end
    nChecks++;
    if ({MultHigh, MultLow, DivHigh, DivLow} !== 128'h0) begin
      nFail++;
      $display("FAIL midrst_results got %h %h %h %h want 0",
               MultHigh, MultLow, DivHigh, DivLow);
    end
    expMH = '0;
    expML = '0;
    expDH = '0;
    expDL = '0;
    sawDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      sawDone |= Done;
    end
    nChecks++;
    if (sawDone !== 1'b0) begin
      nFail++;
      $display("FAIL midrst_no_done got %b want 0", sawDone);
    end
    runOp(1'b0, 32'd3, 32'd4, lat);
    nChecks++;
    if (lat !== 33) begin
      nFail++;
      $display("FAIL midrst_lat got %0d want 33", lat);
    end
    nChecks++;
    if ({MultHigh, MultLow} !== 64'd12) begin
      nFail++;
      $display("FAIL midrst_3x4 got %h_%h want 0_c", MultHigh, MultLow);
    end
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    Op = 1'b0;
    A = '0;
    B = '0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_random();
    test_back_to_back();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule
